// File: rtl/capture_sequencer.sv
// Single-burst oscilloscope capture: arm, wait for a level/slope (or auto) trigger,
// then stream DEPTH decimated {ch2, ch1} sample pairs into the FIFO.
module capture_sequencer #(
   parameter int unsigned DEPTH        = 1024,
   parameter int unsigned AUTO_TIMEOUT = 50000,
   parameter int unsigned CNT_W        = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        arm,
   input  logic        abort,
   input  logic        sample_valid,
   input  logic [11:0] data_ch1,
   input  logic [11:0] data_ch2,
   input  logic        trig_ch,
   input  logic        trig_slope,
   input  logic [11:0] trig_level,
   input  logic        auto_mode,
   input  logic [7:0]  decim,
   input  logic        fifo_full,
   output logic        fifo_wr,
   output logic [23:0] fifo_data,
   output logic        busy,
   output logic        triggered,
   output logic        done,
   output logic        overflow
);
   typedef enum logic [2:0] {IDLE, ARMED, WAIT_TRIG, CAPTURE, DONE} state_t;

   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(AUTO_TIMEOUT - 1);

   state_t state, state_nxt;

   logic             cfg_ch, cfg_slope, cfg_auto;
   logic [11:0]      cfg_level;
   logic [7:0]       cfg_decim;
   logic [11:0]      prev;
   logic [CNT_W-1:0] sample_cnt, tmo_cnt;
   logic [7:0]       dec_cnt;

   logic [11:0] cur;
   logic        level_hit, tmo_hit;
   logic        accept_arm, load_prev, trig_set, do_write, ovf_set;
   logic        cnt_first, tmo_inc, dec_inc, dec_clr;

   assign cur       = cfg_ch ? data_ch2 : data_ch1;
   assign level_hit = cfg_slope ? (prev > cfg_level && cur <= cfg_level)
                                : (prev < cfg_level && cur >= cfg_level);
   assign tmo_hit   = cfg_auto && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // abort > arm > sample_valid falls out of the if/else ordering
   always_comb begin
      state_nxt  = state;
      accept_arm = 1'b0;
      load_prev  = 1'b0;
      trig_set   = 1'b0;
      do_write   = 1'b0;
      ovf_set    = 1'b0;
      cnt_first  = 1'b0;
      tmo_inc    = 1'b0;
      dec_inc    = 1'b0;
      dec_clr    = 1'b0;
      if (abort) begin
         state_nxt = IDLE;
      end else if (arm && (state == IDLE || state == DONE)) begin
         accept_arm = 1'b1;
         state_nxt  = ARMED;
      end else if (sample_valid) begin
         case (state)
            ARMED: begin
               load_prev = 1'b1;
               state_nxt = WAIT_TRIG;
            end
            WAIT_TRIG: begin
               if (level_hit || tmo_hit) begin
                  trig_set = 1'b1;
                  dec_clr  = 1'b1;
                  if (fifo_full) begin
                     ovf_set   = 1'b1;
                     state_nxt = DONE;
                  end else begin
                     do_write  = 1'b1;
                     cnt_first = 1'b1;
                     state_nxt = (DEPTH_C == CNT_W'(1)) ? DONE : CAPTURE;
                  end
               end else begin
                  load_prev = 1'b1;
                  tmo_inc   = (tmo_cnt != TMO_LAST);
               end
            end
            CAPTURE: begin
               if (dec_cnt + 8'd1 == cfg_decim) begin
                  dec_clr = 1'b1;
                  if (fifo_full) begin
                     ovf_set   = 1'b1;
                     state_nxt = DONE;
                  end else begin
                     do_write = 1'b1;
                     if (sample_cnt + CNT_W'(1) == DEPTH_C) state_nxt = DONE;
                  end
               end else begin
                  dec_inc = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cfg_ch     <= 1'b0;
         cfg_slope  <= 1'b0;
         cfg_auto   <= 1'b0;
         cfg_level  <= '0;
         cfg_decim  <= 8'd1;
         prev       <= '0;
         sample_cnt <= '0;
         tmo_cnt    <= '0;
         dec_cnt    <= '0;
         fifo_wr    <= 1'b0;
         fifo_data  <= '0;
         triggered  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         fifo_wr <= do_write;
         if (do_write) fifo_data <= {data_ch2, data_ch1};
         if (accept_arm) begin
            cfg_ch     <= trig_ch;
            cfg_slope  <= trig_slope;
            cfg_auto   <= auto_mode;
            cfg_level  <= trig_level;
            cfg_decim  <= (decim == 8'd0) ? 8'd1 : decim;
            sample_cnt <= '0;
            tmo_cnt    <= '0;
            dec_cnt    <= '0;
            triggered  <= 1'b0;
            overflow   <= 1'b0;
         end else begin
            if (abort)    triggered <= 1'b0;
            if (trig_set) triggered <= 1'b1;
            if (ovf_set)  overflow  <= 1'b1;
            if (load_prev) prev <= cur;
            if (tmo_inc)   tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (dec_clr)      dec_cnt <= '0;
            else if (dec_inc) dec_cnt <= dec_cnt + 8'd1;
            if (cnt_first)                  sample_cnt <= CNT_W'(1);
            else if (do_write && !trig_set) sample_cnt <= sample_cnt + CNT_W'(1);
         end
      end
   end

   assign busy = (state == ARMED) || (state == WAIT_TRIG) || (state == CAPTURE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: table of trigger scenarios plus hand-built
// corner sequences; FIFO writes are checked against a scoreboard queue.
module tb_capture_sequencer;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        arm = 1'b0, abort = 1'b0, sample_valid = 1'b0;
   logic [11:0] data_ch1 = '0, data_ch2 = '0;
   logic        trig_ch = 1'b0, trig_slope = 1'b0, auto_mode = 1'b0, fifo_full = 1'b0;
   logic [11:0] trig_level = '0;
   logic [7:0]  decim = 8'd1;
   logic        fifo_wr, busy, triggered, done, overflow;
   logic [23:0] fifo_data;

   capture_sequencer #(.DEPTH(DEPTH), .AUTO_TIMEOUT(5), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .arm(arm), .abort(abort),
      .sample_valid(sample_valid), .data_ch1(data_ch1), .data_ch2(data_ch2),
      .trig_ch(trig_ch), .trig_slope(trig_slope), .trig_level(trig_level),
      .auto_mode(auto_mode), .decim(decim), .fifo_full(fifo_full),
      .fifo_wr(fifo_wr), .fifo_data(fifo_data), .busy(busy),
      .triggered(triggered), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ch;
      logic        slope;
      logic [11:0] level;
      logic        auto_m;
      int          dec;
      int          s1, st1, s2, st2;
      int          trig_idx;
   } row_t;

   row_t       rows[5];
   logic [23:0] sb[$];
   int checks = 0, errors = 0, wr_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] ramp(input int s, input int st, input int k);
      return 12'(s + st * k);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_sample(input logic [11:0] c1, input logic [11:0] c2, input logic full);
      data_ch1 = c1;
      data_ch2 = c2;
      fifo_full = full;
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      fifo_full = 1'b0;
      tick();
   endtask

   task automatic do_arm(input logic ch, input logic slope, input logic [11:0] lvl,
                         input logic am, input logic [7:0] d);
      trig_ch = ch; trig_slope = slope; trig_level = lvl; auto_mode = am; decim = d;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      // scramble config inputs to show they were latched
      trig_ch = ~ch; trig_slope = ~slope; trig_level = ~lvl; auto_mode = ~am; decim = 8'd7;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic run_row(input int r);
      int d, n, base;
      logic [11:0] c1, c2;
      d = (rows[r].dec == 0) ? 1 : rows[r].dec;
      n = rows[r].trig_idx + (DEPTH - 1) * d + 4;
      base = wr_count;
      do_arm(rows[r].ch, rows[r].slope, rows[r].level, rows[r].auto_m, 8'(rows[r].dec));
      check($sformatf("row%0d busy after arm", r), 32'(busy), 32'd1);
      for (int k = 0; k < n; k++) begin
         c1 = ramp(rows[r].s1, rows[r].st1, k);
         c2 = ramp(rows[r].s2, rows[r].st2, k);
         if (k >= rows[r].trig_idx && (k - rows[r].trig_idx) % d == 0 &&
             (k - rows[r].trig_idx) / d < DEPTH)
            sb.push_back({c2, c1});
         drive_sample(c1, c2, 1'b0);
      end
      tick();
      check($sformatf("row%0d writes", r), 32'(wr_count - base), 32'(DEPTH));
      check($sformatf("row%0d sb empty", r), 32'(sb.size()), 32'd0);
      check($sformatf("row%0d done", r), 32'(done), 32'd1);
      check($sformatf("row%0d busy", r), 32'(busy), 32'd0);
      check($sformatf("row%0d triggered", r), 32'(triggered), 32'd1);
      check($sformatf("row%0d overflow", r), 32'(overflow), 32'd0);
      sb.delete();
   endtask

   initial begin
      int base;
      //          ch    slope  level    auto  dec s1     st1   s2     st2   trig
      rows[0] = '{1'b0, 1'b0, 12'h800, 1'b0, 1, 'h7F0, 8,    'h100, 1,    2};
      rows[1] = '{1'b1, 1'b1, 12'h400, 1'b0, 3, 'h010, 3,    'h405, -2,   3};
      rows[2] = '{1'b1, 1'b0, 12'h200, 1'b0, 0, 'h050, 1,    'h1F0, 'h10, 1};
      rows[3] = '{1'b0, 1'b0, 12'h800, 1'b1, 2, 'h100, 0,    'h000, 1,    5};
      rows[4] = '{1'b1, 1'b0, 12'h30C, 1'b0, 4, 'h700, 'h40, 'h300, 4,    3};

      fork
         forever begin
            @(negedge clk);
            if (fifo_wr === 1'b1) begin
               wr_count++;
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected write: got %0h expected no write", fifo_data);
               end else begin
                  logic [23:0] e;
                  e = sb.pop_front();
                  if (fifo_data !== e) begin
                     errors++;
                     $display("FAIL fifo_data: got %0h expected %0h", fifo_data, e);
                  end
               end
            end
         end
      join_none

      #23;
      check("reset fifo_wr", 32'(fifo_wr), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset fifo_data", 32'(fifo_data), 32'd0);
      reset = 1'b0;
      tick();

      for (int r = 0; r < 5; r++) run_row(r);

      // auto mode off: constant input never triggers
      base = wr_count;
      do_arm(1'b0, 1'b0, 12'h800, 1'b0, 8'd1);
      for (int k = 0; k < 12; k++) drive_sample(12'h100, 12'h100, 1'b0);
      check("noauto busy", 32'(busy), 32'd1);
      check("noauto triggered", 32'(triggered), 32'd0);
      check("noauto writes", 32'(wr_count - base), 32'd0);
      pulse_abort();
      check("noauto abort busy", 32'(busy), 32'd0);

      // overflow on 4th due write
      base = wr_count;
      do_arm(1'b0, 1'b0, 12'h800, 1'b0, 8'd1);
      for (int k = 0; k < 9; k++) begin
         if (k >= 2 && k <= 4) sb.push_back({ramp('h100, 1, k), ramp('h7F0, 8, k)});
         drive_sample(ramp('h7F0, 8, k), ramp('h100, 1, k), k == 5);
      end
      tick();
      check("ovf writes", 32'(wr_count - base), 32'd3);
      check("ovf overflow", 32'(overflow), 32'd1);
      check("ovf done", 32'(done), 32'd1);
      check("ovf sb empty", 32'(sb.size()), 32'd0);
      sb.delete();
      do_arm(1'b0, 1'b0, 12'h800, 1'b0, 8'd1);
      check("rearm overflow", 32'(overflow), 32'd0);
      check("rearm done", 32'(done), 32'd0);
      pulse_abort();

      // abort after two writes
      base = wr_count;
      do_arm(1'b0, 1'b0, 12'h800, 1'b0, 8'd1);
      for (int k = 0; k < 4; k++) begin
         if (k >= 2) sb.push_back({ramp('h100, 1, k), ramp('h7F0, 8, k)});
         drive_sample(ramp('h7F0, 8, k), ramp('h100, 1, k), 1'b0);
      end
      pulse_abort();
      check("abort busy", 32'(busy), 32'd0);
      check("abort triggered", 32'(triggered), 32'd0);
      for (int k = 4; k < 8; k++) drive_sample(ramp('h7F0, 8, k), ramp('h100, 1, k), 1'b0);
      check("abort writes", 32'(wr_count - base), 32'd2);
      check("abort done", 32'(done), 32'd0);
      sb.delete();

      // arm and abort together from IDLE
      arm = 1'b1; abort = 1'b1;
      tick();
      arm = 1'b0; abort = 1'b0;
      check("arm+abort busy", 32'(busy), 32'd0);

      // arm while busy is ignored
      base = wr_count;
      do_arm(1'b0, 1'b0, 12'h800, 1'b0, 8'd1);
      for (int k = 0; k < 13; k++) begin
         if (k == 2) begin
            trig_ch = 1'b1; trig_slope = 1'b1; trig_level = 12'h000; decim = 8'd2;
            arm = 1'b1;
            tick();
            arm = 1'b0;
         end
         if (k >= 2 && k < 10) sb.push_back({ramp('h100, 1, k), ramp('h7F0, 8, k)});
         drive_sample(ramp('h7F0, 8, k), ramp('h100, 1, k), 1'b0);
      end
      tick();
      check("busyarm writes", 32'(wr_count - base), 32'd8);
      check("busyarm done", 32'(done), 32'd1);
      check("busyarm sb empty", 32'(sb.size()), 32'd0);
      sb.delete();

      // async reset mid-capture
      base = wr_count;
      do_arm(1'b0, 1'b0, 12'h800, 1'b0, 8'd1);
      for (int k = 0; k < 4; k++) begin
         if (k >= 2) sb.push_back({ramp('h100, 1, k), ramp('h7F0, 8, k)});
         drive_sample(ramp('h7F0, 8, k), ramp('h100, 1, k), 1'b0);
      end
      #3 reset = 1'b1;
      #1;
      check("areset fifo_data", 32'(fifo_data), 32'd0);
      check("areset busy", 32'(busy), 32'd0);
      check("areset triggered", 32'(triggered), 32'd0);
      check("areset fifo_wr", 32'(fifo_wr), 32'd0);
      #10 reset = 1'b0;
      tick();
      sb.delete();
      for (int k = 4; k < 8; k++) drive_sample(ramp('h7F0, 8, k), ramp('h100, 1, k), 1'b0);
      check("post-reset writes", 32'(wr_count - base), 32'd2);
      check("post-reset busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
